instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Encodes symbolic instruction requests into 32-bit LEGv8 machine words and writes them sequentially into instruction memory.
- It is the inverse of the control/opcode decoder: it produces exactly the opcode bit patterns the decoder recognises. Supported ops: B, B.LT, ADDI, ADDS, CBZ, LDUR, STUR, SUBS, LSL, LSR, MUL.
- Sits between the testbench/boot-loader front end and the instruction-memory write port. Used to preload programs before the CPU leaves reset.

Parameters:
ADDR_W, 32, width of the instruction-memory byte address.
BASE_ADDR, 0, byte address of the first word written after reset/clear.
DEPTH, 64, maximum number of words per load window.
CNT_W, 7, width of count; must hold 0..DEPTH.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
clear  in  1  synchronous restart of the load window; ignored unless the FSM is in IDLE.
in_valid  in  1  request valid.
in_ready  out  1  encoder can accept a request.
op  in  4  0 ADDI, 1 ADDS, 2 SUBS, 3 MUL, 4 LSL, 5 LSR, 6 LDUR, 7 STUR, 8 B, 9 B.LT, 10 CBZ, 11-15 illegal.
rd  in  5  destination, or Rt for LDUR/STUR/CBZ.
rn  in  5  first source/base register.
rm  in  5  second source register.
shamt  in  6  shift amount for LSL/LSR.
imm  in  26  two's-complement immediate or branch offset in words.
wr_en  out  1  memory write strobe.
wr_addr  out  ADDR_W  byte address of the word being written.
wr_data  out  32  encoded instruction.
wr_ack  in  1  memory has accepted the write.
count  out  CNT_W  words written in the current window.
full  out  1  count == DEPTH.
err  out  1  one-cycle pulse on a rejected request.
err_code  out  2  01 illegal op, 10 immediate out of range; holds its value until the next err pulse or reset.

Behaviour:
- Reset values: in_ready=1, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, count=0, full=0, err=0, err_code=00, FSM=IDLE.
- Reset during WRITE aborts the write: wr_en=0 on the next cycle and no count increment.
- FSM states: IDLE -> ENC -> WRITE -> IDLE.
  - ENC -> IDLE directly on error.
- Handshake: a request is accepted on the edge where in_valid && in_ready.
  - in_ready = (state==IDLE) && !full.
  - All fields are latched on acceptance.
- ENC (cycle N+1 after acceptance):
  - Range-check the request and form wr_data.
  - On error: err=1 for one cycle with err_code set, no write, return to IDLE.
  - Otherwise go to WRITE.
- WRITE: wr_en=1, with wr_addr and wr_data stable, until the cycle wr_ack=1.
  - That edge: wr_addr += 4, count += 1, state -> IDLE.
  - An ack in the same cycle wr_en first rises completes immediately.
  - wr_ack is ignored outside WRITE.
- Minimum throughput: one word per 3 cycles.
- full asserts the cycle count reaches DEPTH. in_valid is then ignored until clear or reset.
- clear in IDLE: wr_addr=BASE_ADDR, count=0, full=0. clear has priority over a same-cycle request, which is not accepted.
- Encodings (bit 31 down to 0):
  - ADDI: 1001000100 | imm[11:0] | rn | rd. imm must be 0..4095, else err 10.
  - ADDS: 10101011000 | rm | 000000 | rn | rd.
  - SUBS: 11101011000 | rm | 000000 | rn | rd.
  - MUL: 10011011000 | rm | 011111 | rn | rd.
  - LSL: 11010011011 | 00000 | shamt | rn | rd.
  - LSR: 11010011010 | 00000 | shamt | rn | rd.
  - LDUR: 11111000010 | imm[8:0] | 00 | rn | rd. imm must be -256..255.
  - STUR: 11111000000 | imm[8:0] | 00 | rn | rd. imm must be -256..255.
  - B: 000101 | imm[25:0]. Any imm is valid.
  - B.LT: 01010100 | imm[18:0] | 01011. imm must be -2^18..2^18-1.
  - CBZ: 10110100 | imm[18:0] | rd. imm must be -2^18..2^18-1.
- Range checks interpret imm as a signed 26-bit value, except ADDI, where the value is treated as unsigned and must be < 4096.
- Unused input fields are don't-care and must not affect wr_data.

Test Plan:
- Reset, then ADDI rd=1 rn=2 imm=5 with wr_ack held high -> wr_en high for one cycle, wr_data=0x91001441, wr_addr=0; afterwards count=1 and wr_addr=4.
- B imm=-1, then LDUR rd=3 rn=4 imm=-8, then B.LT imm=2 -> wr_data 0x17FFFFFF, 0xF85F8083, 0x5400004B at addresses 0, 4, 8.
- op=12, and separately ADDI imm=4096 -> err pulses once each with err_code 01 then 10; wr_en never rises; count unchanged.
- DEPTH=4: issue 5 requests with wr_ack delayed 3 cycles each -> wr_en held for 3 cycles per word; full=1 and in_ready=0 after the 4th write; the 5th request is not accepted; clear -> count=0, wr_addr=0, in_ready=1.
- Assert reset while in WRITE with wr_ack=0 -> next cycle wr_en=0, count=0, wr_addr=BASE_ADDR; the following request is written at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes LEGv8 requests (in_valid/in_ready, op/rd/rn/rm/shamt/imm) into 32-bit words written via wr_en/wr_addr/wr_data/wr_ack, with count/full/err/err_code status
module instr_encoder_loader #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [5:0]        shamt,
  input  logic [25:0]       imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ack,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);
  typedef enum logic [1:0] {IDLE, ENC, WRITE} state_t;
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [4:0] rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [5:0] shamt_q, shamt_d;
  logic [25:0] imm_q, imm_d;
  logic [31:0] wr_data_q, wr_data_d, word;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0] err_code_q, err_code_d, code;
  logic fit9, fit19;
  assign fit9  = &imm_q[25:8] | ~|imm_q[25:8];
  assign fit19 = &imm_q[25:18] | ~|imm_q[25:18];
  always_comb begin
    word = '0;
    code = 2'b00;
    case (op_q)
      4'd0: begin
        word = {10'b1001000100, imm_q[11:0], rn_q, rd_q};
        code = |imm_q[25:12] ? 2'b10 : 2'b00;
      end
      4'd1: word = {11'b10101011000, rm_q, 6'b000000, rn_q, rd_q};
      4'd2: word = {11'b11101011000, rm_q, 6'b000000, rn_q, rd_q};
      4'd3: word = {11'b10011011000, rm_q, 6'b011111, rn_q, rd_q};
      4'd4: word = {11'b11010011011, 5'b00000, shamt_q, rn_q, rd_q};
      4'd5: word = {11'b11010011010, 5'b00000, shamt_q, rn_q, rd_q};
      4'd6: begin
        word = {11'b11111000010, imm_q[8:0], 2'b00, rn_q, rd_q};
        code = fit9 ? 2'b00 : 2'b10;
      end
      4'd7: begin
        word = {11'b11111000000, imm_q[8:0], 2'b00, rn_q, rd_q};
        code = fit9 ? 2'b00 : 2'b10;
      end
      4'd8: word = {6'b000101, imm_q};
      4'd9: begin
        word = {8'b01010100, imm_q[18:0], 5'b01011};
        code = fit19 ? 2'b00 : 2'b10;
      end
      4'd10: begin
        word = {8'b10110100, imm_q[18:0], rd_q};
        code = fit19 ? 2'b00 : 2'b10;
      end
      default: code = 2'b01;
    endcase
  end
  assign full     = count_q == CNT_W'(DEPTH);
  assign in_ready = (state_q == IDLE) && !full;
  assign wr_en    = state_q == WRITE;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign count    = count_q;
  assign err      = (state_q == ENC) && |code;
  assign err_code = err ? code : err_code_q;
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rn_d       = rn_q;
    rm_d       = rm_q;
    shamt_d    = shamt_q;
    imm_d      = imm_q;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    count_d    = count_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          wr_addr_d = BASE_ADDR;
          count_d   = '0;
        end else if (in_valid && in_ready) begin
          op_d    = op;
          rd_d    = rd;
          rn_d    = rn;
          rm_d    = rm;
          shamt_d = shamt;
          imm_d   = imm;
          state_d = ENC;
        end
      end
      ENC: begin
        if (|code) begin
          err_code_d = code;
          state_d    = IDLE;
        end else begin
          wr_data_d = word;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (wr_ack) begin
          wr_addr_d = wr_addr_q + ADDR_W'(4);
          count_d   = count_q + CNT_W'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      shamt_q    <= '0;
      imm_q      <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= BASE_ADDR;
      count_q    <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rn_q       <= rn_d;
      rm_q       <= rm_d;
      shamt_q    <= shamt_d;
      imm_q      <= imm_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      count_q    <= count_d;
      err_code_q <= err_code_d;
    end
  end
endmodule
